serial_addsub16_ctrl: RTL and testbench
=======================================

SERIAL_ADDSUB16_CTRL -- requirements
Module: serial_addsub16_ctrl

Interface
REQ-001 The block SHALL have these ports, in this order:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- sub  input  1  operation select: 0 = A+B, 1 = A-B; latched with start.
- a  input  16  operand A; latched with start.
- b  input  16  operand B; latched with start.
- busy  output  1  high while nibbles are being computed (RUN).
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  16  sum/difference, two's complement.
- cout  output  1  carry out of bit 15 (for sub, 1 = no borrow).
- ovf  output  1  signed overflow.
- zero  output  1  result == 0x0000.

REQ-002 One clock; reset is synchronous and active-high. The clock port SHALL be clk and the reset port SHALL be rst.

Function
REQ-003 The block SHALL compute a 16-bit add/subtract by sequencing one 4-bit add/sub stage over four nibbles, LSB nibble first.
REQ-004 FSM states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN when start=1.
- RUN -> DONE after the fourth nibble.
- DONE -> IDLE unconditionally.
REQ-005 On acceptance (IDLE and start=1), the block SHALL latch a, b and sub into internal registers, clear the nibble index to 0, and preset the carry register to sub.
REQ-006 Each RUN cycle SHALL compute a[4k+3:4k] + (b[4k+3:4k] XOR {4{sub}}) + carry, where k is the nibble index. It SHALL write the 4-bit sum into result[4k+3:4k], store the carry out, and increment k. k is 2 bits wide and wraps 3->0 only on leaving RUN.
REQ-007 Timing: if start is high in cycle 0, busy SHALL be high in cycles 1-4, done SHALL be high in cycle 5 only, and IDLE SHALL be re-entered in cycle 6.
REQ-008 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE).
REQ-009 cout SHALL be the carry out of nibble 3.
REQ-010 ovf SHALL be (A[15] == B'[15]) AND (result[15] != A[15]), where B' = b XOR {16{sub}}.
REQ-011 zero SHALL be (result == 0).
REQ-012 cout, ovf and zero SHALL be updated at the end of the fourth RUN cycle, so they are valid together with done.
REQ-013 result, cout, ovf and zero SHALL hold their values from done until the next accepted start. During RUN their contents are undefined to the consumer.
REQ-014 start SHALL be ignored in RUN and DONE; no queuing and no restart.
REQ-015 Changes on a, b or sub after acceptance SHALL NOT affect the operation in flight.
REQ-016 A start held high continuously SHALL begin a new operation on every return to IDLE, giving one operation per 6 cycles.
REQ-017 Arithmetic SHALL be modulo 2^16; no saturation.

Reset
REQ-018 rst=1 at a rising edge SHALL force:
- state to IDLE and nibble index to 0;
- result to 0x0000;
- cout, ovf, busy and done to 0;
- zero to 1 (consistent with result=0);
- internal operand and carry registers to 0.
REQ-019 rst SHALL take priority over start and over any in-flight operation. An aborted operation SHALL produce no done pulse.
REQ-020 A start asserted in the first cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-021 Add: a=0x1234, b=0x1111, sub=0, start in cycle 0 -> done in cycle 5 only, result=0x2345, cout=0, ovf=0, zero=0.
REQ-022 Wrap: a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, cout=1, ovf=0, zero=1. Also a=0x7FFF, b=0x0001, sub=0 -> result=0x8000, cout=0, ovf=1.
REQ-023 Subtract: a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 -> result=0x7FFF, cout=1, ovf=1.
REQ-024 Ignore and isolate: start pulsed in cycle 2, with a/b/sub changed in cycles 1-4 -> no second operation, first result unaffected, and done pulses exactly once.
REQ-025 Reset mid-run: rst in cycle 3 of a run -> next cycle busy=0, done=0, result=0x0000, zero=1, no done pulse. Then start with a=0x0001, b=0x0002, sub=0 -> result=0x0003 after 5 cycles.
REQ-026 Back-to-back: start held high for 12 cycles with fixed operands -> done pulses in cycles 5 and 11, and busy is low in cycles 0, 5, 6 and 11.

Source files
------------

// File: rtl/serial_addsub16_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub16_ctrl
// Purpose  : 16-bit add/subtract computed serially, one 4-bit nibble per
//            clock (LSB nibble first), through a single 4-bit adder stage.
//            IDLE -> RUN (4 cycles) -> DONE (1 cycle) -> IDLE.
// Ports    : clk    - clock, rising edge
//            rst    - synchronous active-high reset
//            start  - begin an operation (sampled only in IDLE)
//            sub    - 0: A+B, 1: A-B (latched with start)
//            a, b   - 16-bit operands (latched with start)
//            busy   - high while nibbles are being computed
//            done   - one-cycle pulse, result and flags valid
//            result - 16-bit two's complement sum/difference
//            cout   - carry out of bit 15 (for sub, 1 = no borrow)
//            ovf    - signed overflow
//            zero   - result == 0
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub16_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cout,
  output logic        ovf,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;
  logic        carry;
  logic [1:0]  idx;

  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [4:0]  nib_sum;

  // Single shared 4-bit stage; subtraction is A + ~B + 1, the +1 coming
  // from the carry register preset to sub at acceptance.
  always_comb begin
    nib_a   = op_a[{idx, 2'b00} +: 4];
    nib_b   = op_b[{idx, 2'b00} +: 4] ^ {4{op_sub}};
    nib_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == 2'd3) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= 16'h0000;
      op_b   <= 16'h0000;
      op_sub <= 1'b0;
      carry  <= 1'b0;
      idx    <= 2'd0;
      result <= 16'h0000;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            op_sub <= sub;
            carry  <= sub;
            idx    <= 2'd0;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= nib_sum[3:0];
          carry                     <= nib_sum[4];
          // 2-bit index naturally wraps 3 -> 0 as RUN is left.
          idx                       <= idx + 2'd1;
          if (idx == 2'd3) begin
            // Flags are formed from the top nibble as it is written so that
            // they become valid on the same edge as the final result bits.
            cout <= nib_sum[4];
            ovf  <= (nib_a[3] == nib_b[3]) && (nib_sum[3] != nib_a[3]);
            zero <= ({nib_sum[3:0], result[11:0]} == 16'h0000);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub16_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub16_ctrl
// Purpose  : Directed self-checking bench for serial_addsub16_ctrl.
//            Cycle n is the interval following the n-th rising edge of an
//            operation; outputs are sampled 1 time unit after that edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub16_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_cmp;
  int n_err;

  serial_addsub16_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation in the current cycle (cycle 0) and checks the
  // whole sequence through cycle 6.
  task automatic run_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                        input logic vs, input logic [15:0] er, input logic ec,
                        input logic ev, input logic ez);
    a = va; b = vb; sub = vs; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("%s busy c%0d", name, i), {31'd0, busy}, 32'd1);
      check($sformatf("%s done c%0d", name, i), {31'd0, done}, 32'd0);
      step();
    end
    check({name, " done c5"},   {31'd0, done}, 32'd1);
    check({name, " busy c5"},   {31'd0, busy}, 32'd0);
    check({name, " result"},    {16'd0, result}, {16'd0, er});
    check({name, " cout"},      {31'd0, cout}, {31'd0, ec});
    check({name, " ovf"},       {31'd0, ovf},  {31'd0, ev});
    check({name, " zero"},      {31'd0, zero}, {31'd0, ez});
    step();
    check({name, " done c6"},   {31'd0, done}, 32'd0);
    check({name, " hold"},      {16'd0, result}, {16'd0, er});
  endtask

  initial begin
    int done_cnt;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = 16'h0; b = 16'h0;
    step(); step();
    check("rst result", {16'd0, result}, 32'h0);
    check("rst zero",   {31'd0, zero}, 32'd1);
    check("rst cout",   {31'd0, cout}, 32'd0);
    check("rst ovf",    {31'd0, ovf},  32'd0);
    check("rst busy",   {31'd0, busy}, 32'd0);
    check("rst done",   {31'd0, done}, 32'd0);
    // Start in the first cycle after reset release.
    rst = 1'b0;
    run_op("add",    16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    run_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("ovfadd", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("subneg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("subeq",  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("nibcy",  16'h0FF8, 16'h0008, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

    // Ignore start in RUN and isolate from operand changes.
    done_cnt = 0;
    a = 16'h1000; b = 16'h0234; sub = 1'b0; start = 1'b1;
    step();                                       // cycle 1
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (done) begin
        done_cnt++;
        check("iso result", {16'd0, result}, 32'h1234);
        check("iso cycle", i, 5);
      end
      a = 16'hFFFF ^ 16'(i); b = 16'hA5A5 + 16'(i); sub = i[0];
      start = (i == 2);
      step();
    end
    start = 1'b0;
    check("iso done count", done_cnt, 1);
    check("iso idle", {31'd0, busy}, 32'd0);

    // Reset mid-run.
    a = 16'h1234; b = 16'h0001; sub = 1'b0; start = 1'b1;
    step();                                       // cycle 1
    start = 1'b0;
    step();                                       // cycle 2
    step();                                       // cycle 3
    rst = 1'b1;
    step();                                       // cycle 4
    rst = 1'b0;
    check("abort busy",   {31'd0, busy}, 32'd0);
    check("abort done",   {31'd0, done}, 32'd0);
    check("abort result", {16'd0, result}, 32'h0);
    check("abort zero",   {31'd0, zero}, 32'd1);
    run_op("postrst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high.
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("b2b done c%0d", i), {31'd0, done},
            (i == 5 || i == 11) ? 32'd1 : 32'd0);
      check($sformatf("b2b busy c%0d", i), {31'd0, busy},
            (i == 0 || i == 5 || i == 6 || i == 11) ? 32'd0 : 32'd1);
      if (i == 5 || i == 11) check("b2b result", {16'd0, result}, 32'h0100);
      step();
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
